div_iter_unit: RTL and testbench
================================

# div_iter_unit

Parametrised, area-reduced successor to the fully pipelined divider in `mul_div_modules`. It is a single-issue iterative restoring divider that retires `BITS_PER_CYCLE` quotient bits per clock and skips the leading-zero bits of the dividend. Divide-by-zero and signed overflow resolve on a one-cycle fast path. It sits behind the EX-stage mul/div dispatch with valid/ready handshakes on both sides and supports pipeline flush.

## Interface
- `XLEN`, 32: operand/result width; legal values 32, 64.
- `BITS_PER_CYCLE`, 2: restoring steps unrolled per clock; legal values 1, 2, 4; must divide XLEN.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept; high exactly when state is IDLE.
- `dividend`  in  XLEN  rs1.
- `divisor`  in  XLEN  rs2.
- `MUL_DIV_ctrl`  in  3  [0]=unsigned, [1]=remainder select, [2] ignored.
- `flush`  in  1  kill any in-flight operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `DIV_out`  out  XLEN  quotient or remainder per ctrl[1].
- `busy`  out  1  high in PREP, ITER, FIX, DONE.

## Operation
- Accept on a rising edge with `in_valid & in_ready & ~flush`. Latch the operands, ctrl, and both sign bits. Signed mode is `ctrl[0]=0`.
- **PREP (1 cycle).**
  - Form the magnitudes |a| and |d|; a negative operand is two's-complement negated only in signed mode.
  - Compute `skip = floor(clz(|a|)/BITS_PER_CYCLE)*BITS_PER_CYCLE`.
  - Set the working dividend to `|a| << skip` and the iteration count `N = (XLEN-skip)/BITS_PER_CYCLE`.
  - Clear the partial remainder (XLEN+1 bits) and the quotient.
- **Fast path, taken from PREP straight to DONE:**
  - d==0: quotient = all ones; remainder = dividend as input (unsigned bits).
  - Signed, a==1<<(XLEN-1), d==all ones: quotient = a; remainder = 0.
  - |a|==0 (N=0): quotient = 0; remainder = 0.
- **ITER (N cycles).** Each cycle performs `BITS_PER_CYCLE` chained restoring steps:
  - `r = {r, next MSB of working dividend}`.
  - If `r >= |d|`, then `r -= |d|` and the quotient bit is 1; otherwise the quotient bit is 0.
  - The quotient shifts left one bit per step.
  - A cycle counter decrements; leave ITER when it reaches 0.
- **FIX (1 cycle).**
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend is negative.
  - Select the result by ctrl[1] into the output register.
- **DONE.** Hold `out_valid=1` and a stable `DIV_out` until `out_ready`. On the handshake edge, move to IDLE.
- **State transitions:**
  - IDLE→PREP on accept.
  - PREP→ITER, or PREP→DONE on the fast path.
  - ITER→ITER while count>1, ITER→FIX on the last cycle.
  - FIX→DONE; DONE→IDLE on `out_ready`.
- **flush.**
  - From any state, the next edge goes to IDLE, `out_valid` deasserts, and the result is discarded.
  - flush has priority over accept and over the DONE handshake in the same cycle.
- All arithmetic is modulo 2^XLEN. The partial remainder is XLEN+1 bits so the compare/subtract cannot overflow when |d| ≥ 2^(XLEN-1).

## Timing
- **Reset values:** state IDLE, `out_valid=0`, `DIV_out=0`, `busy=0`, `in_ready=1`; counter, quotient and remainder all zero.
- **Latency** is counted as edges from the accepting edge to the edge after which `out_valid` is first high.
  - Normal path: N+2.
  - Fast path: 1.
  - Worst case is XLEN/BITS_PER_CYCLE+2 (18 for 32/2).
- **Throughput:** one operation in flight. The next accept is possible in the cycle after the output handshake.
- `DIV_out` changes only on the FIX→DONE edge, the fast-path PREP→DONE edge, or reset. It holds its value in IDLE.
- `in_ready` and `busy` are decoded from registered state only.
- Reset asserted mid-operation clears everything asynchronously. No output pulse follows deassertion.

## Test plan
- **Unsigned divide, short dividend.** XLEN=32/BPC=2; DIVU 100/7 (ctrl=3'b001) → skip=24, N=4, `out_valid` at latency 6, `DIV_out=14`. REMU of the same operands (3'b011) → 2.
- **Signed signs, full length.**
  - DIV −7/2 (0xFFFFFFF9, 0x2, ctrl=0) → 0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/1 → N=16, latency 18, 0xFFFFFFFF.
- **Special cases.**
  - DIV 5/0 → 0xFFFFFFFF at latency 1; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - DIV 0/9 → 0 at latency 1.
- **Backpressure.** Hold `out_ready=0` for 5 cycles after `out_valid` → `DIV_out` stable, `in_ready=0`, `busy=1`. Release → IDLE next edge. Check a back-to-back second op is accepted one cycle later.
- **Flush and reset mid-operation.**
  - Flush in the 3rd ITER cycle with `in_valid` high → no accept that edge, IDLE next edge, no `out_valid`.
  - A subsequent DIVU 100/7 still returns 14.
  - Assert `rst_n` low mid-ITER → all outputs reach reset values immediately.
- **Parameter sweep.** Randomised 10k ops for (32,1), (32,4), (64,2) against a reference model, all ctrl values. Check latency equals N+2 or 1 exactly.

Source files
------------

// File: rtl/div_iter_unit.sv
// Iterative restoring divider: BITS_PER_CYCLE quotient bits per clock, skips the
// dividend's leading zeros, one-cycle fast path for divide-by-zero/overflow/zero.
module div_iter_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [2:0]      MUL_DIV_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] DIV_out,
    output logic            busy
);
    localparam int CW  = $clog2(XLEN / BITS_PER_CYCLE + 1);
    localparam int LZW = $clog2(XLEN + 1);
    localparam int BSH = $clog2(BITS_PER_CYCLE);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, dv_q, dv_d;
    logic            uns_q, uns_d, rsel_q, rsel_d, sa_q, sa_d, sd_q, sd_d;
    logic [XLEN-1:0] dmag_q, dmag_d, work_q, work_d, quo_q, quo_d, out_q, out_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            ctrl_unused;
    assign ctrl_unused = MUL_DIV_ctrl[2];

    // Operand preparation: magnitudes, leading-zero skip, iteration count
    logic [XLEN-1:0] amag_c, dmag_c, work_c, q_fast, r_fast, q_fix, r_fix;
    logic [LZW-1:0]  lz_c, skip_c, span_c;
    logic [CW-1:0]   n_c;
    logic            d_zero, ovf, a_zero;

    always_comb begin
        amag_c = (sa_q & ~uns_q) ? -a_q : a_q;
        dmag_c = (sd_q & ~uns_q) ? -dv_q : dv_q;
        lz_c   = LZW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (amag_c[i]) lz_c = LZW'(XLEN - 1 - i);
        end
        skip_c = lz_c & ~LZW'(BITS_PER_CYCLE - 1);
        span_c = LZW'(XLEN) - skip_c;
        n_c    = CW'(span_c >> BSH);
        work_c = amag_c << skip_c;
        d_zero = (dv_q == '0);
        ovf    = ~uns_q & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (dv_q == '1);
        a_zero = (amag_c == '0);
        q_fast = '0;
        r_fast = '0;
        if (d_zero) begin
            q_fast = '1;
            r_fast = a_q;
        end else if (ovf) begin
            q_fast = a_q;
        end
    end

    // Chained restoring steps for one ITER cycle
    logic [XLEN:0]   rem_it;
    logic [XLEN-1:0] work_it, quo_it;

    always_comb begin
        rem_it  = rem_q;
        work_it = work_q;
        quo_it  = quo_q;
        for (int s = 0; s < BITS_PER_CYCLE; s++) begin
            rem_it  = {rem_it[XLEN-1:0], work_it[XLEN-1]};
            work_it = work_it << 1;
            if (rem_it >= {1'b0, dmag_q}) begin
                rem_it = rem_it - {1'b0, dmag_q};
                quo_it = {quo_it[XLEN-2:0], 1'b1};
            end else begin
                quo_it = {quo_it[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        q_fix = (~uns_q & (sa_q ^ sd_q)) ? -quo_q : quo_q;
        r_fix = (~uns_q & sa_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        dv_d    = dv_q;
        uns_d   = uns_q;
        rsel_d  = rsel_q;
        sa_d    = sa_q;
        sd_d    = sd_q;
        dmag_d  = dmag_q;
        work_d  = work_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_PREP;
                        a_d     = dividend;
                        dv_d    = divisor;
                        uns_d   = MUL_DIV_ctrl[0];
                        rsel_d  = MUL_DIV_ctrl[1];
                        sa_d    = dividend[XLEN-1];
                        sd_d    = divisor[XLEN-1];
                    end
                end
                S_PREP: begin
                    dmag_d = dmag_c;
                    work_d = work_c;
                    cnt_d  = n_c;
                    rem_d  = '0;
                    quo_d  = '0;
                    if (d_zero | ovf | a_zero) begin
                        state_d = S_DONE;
                        out_d   = rsel_q ? r_fast : q_fast;
                    end else begin
                        state_d = S_ITER;
                    end
                end
                S_ITER: begin
                    rem_d  = rem_it;
                    work_d = work_it;
                    quo_d  = quo_it;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q <= CW'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    out_d   = rsel_q ? r_fix : q_fix;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            dv_q    <= '0;
            uns_q   <= 1'b0;
            rsel_q  <= 1'b0;
            sa_q    <= 1'b0;
            sd_q    <= 1'b0;
            dmag_q  <= '0;
            work_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            dv_q    <= dv_d;
            uns_q   <= uns_d;
            rsel_q  <= rsel_d;
            sa_q    <= sa_d;
            sd_q    <= sd_d;
            dmag_q  <= dmag_d;
            work_q  <= work_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign DIV_out   = out_q;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed vector table, multi-cycle corner sequences and a random sweep
// against a behavioural reference for div_iter_unit (XLEN=32, 2 bits/cycle).
module tb_div_iter_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [31:0] dividend, divisor, DIV_out;
    logic [2:0]  ctrl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .MUL_DIV_ctrl(ctrl),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .DIV_out(DIV_out), .busy(busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] d,
                                             input logic [2:0] c);
        logic [31:0] q, r;
        if (d == 0) begin
            q = '1; r = a;
        end else if (!c[0] && a == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = a; r = 0;
        end else if (c[0]) begin
            q = a / d; r = a % d;
        end else begin
            q = 32'($signed(a) / $signed(d));
            r = 32'($signed(a) % $signed(d));
        end
        return c[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] c);
        logic [31:0] mag;
        int lz;
        if (d == 0) return 1;
        if (!c[0] && a == 32'h8000_0000 && d == 32'hFFFF_FFFF) return 1;
        mag = (!c[0] && a[31]) ? -a : a;
        if (mag == 0) return 1;
        lz = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) break;
            lz++;
        end
        return (32 - (lz / 2) * 2) / 2 + 2;
    endfunction

    // Issue one op; returns first DIV_out with out_valid high and the latency in edges.
    task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        check("in_ready_pre_accept", in_ready, 1);
        dividend = a; divisor = d; ctrl = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        res = DIV_out;
        $display("[TB] op a=%h d=%h ctrl=%0d -> %h latency %0d", a, d, c, res, lat);
    endtask

    task automatic finish_op();
        @(posedge clk);
        #1;
        check("idle_after_handshake", {in_ready, out_valid, busy}, 3'b100);
    endtask

    logic [31:0] res, held, a, d;
    logic [2:0]  c;
    int          lat, seen;

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         3'b001, 32'd14,        6};
        vecs[1]  = '{32'd100,       32'd7,         3'b011, 32'd2,         6};
        vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         3'b000, 32'hFFFF_FFFD, 4};
        vecs[3]  = '{32'hFFFF_FFF9, 32'd2,         3'b010, 32'hFFFF_FFFF, 4};
        vecs[4]  = '{32'hFFFF_FFFF, 32'd1,         3'b001, 32'hFFFF_FFFF, 18};
        vecs[5]  = '{32'd5,         32'd0,         3'b000, 32'hFFFF_FFFF, 1};
        vecs[6]  = '{32'd5,         32'd0,         3'b010, 32'd5,         1};
        vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 32'h8000_0000, 1};
        vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b010, 32'd0,         1};
        vecs[9]  = '{32'd0,         32'd9,         3'b000, 32'd0,         1};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b001, 32'd0,         18};
        vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 32'h8000_0000, 18};
        vecs[12] = '{32'hFFFF_FF9C, 32'd7,         3'b010, 32'hFFFF_FFFE, 6};
        vecs[13] = '{32'd100,       32'hFFFF_FFF9, 3'b100, 32'hFFFF_FFF2, 6};
        vecs[14] = '{32'hFFFF_FFFF, 32'h8000_0000, 3'b001, 32'd1,         18};
        vecs[15] = '{32'hFFFF_FFFF, 32'h8000_0000, 3'b011, 32'h7FFF_FFFF, 18};
        vecs[16] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 32'd1,         3};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0; ctrl = '0;
        #12;
        check("reset_state", {in_ready, busy, out_valid, DIV_out}, {3'b100, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].a, vecs[i].d, vecs[i].c, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            finish_op();
        end

        // Backpressure, then back-to-back accept right after the handshake
        out_ready = 1'b0;
        run_op(32'd100, 32'd7, 3'b001, held, lat);
        check("bp_result", held, 32'd14);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {out_valid, in_ready, busy, DIV_out}, {3'b101, held});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", {in_ready, out_valid}, 2'b10);
        run_op(32'd100, 32'd7, 3'b011, res, lat);
        check("b2b_result", res, 32'd2);
        check("b2b_latency", lat, 6);
        finish_op();

        // Flush in the third ITER cycle with a competing request present
        @(negedge clk);
        dividend = 32'hFFFF_FFFF; divisor = 32'd1; ctrl = 3'b001; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle", {in_ready, busy, out_valid}, 3'b100);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("flush_no_output", seen, 0);
        run_op(32'd100, 32'd7, 3'b001, res, lat);
        check("post_flush_result", res, 32'd14);
        finish_op();

        // Asynchronous reset in the middle of ITER
        @(negedge clk);
        dividend = 32'hFFFF_FFFF; divisor = 32'd3; ctrl = 3'b001; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, busy, out_valid, DIV_out}, {3'b100, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("reset_no_output", seen, 0);

        // Random sweep against the reference model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = $urandom_range(0, 1000);
                2: a = $urandom >> $urandom_range(0, 31);
                default: a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'd0;
            endcase
            case ($urandom_range(0, 4))
                0: d = $urandom;
                1: d = $urandom_range(1, 50);
                2: d = $urandom >> $urandom_range(0, 31);
                3: d = 32'hFFFF_FFFF;
                default: d = 32'd0;
            endcase
            c = 3'($urandom_range(0, 7));
            run_op(a, d, c, res, lat);
            check("rand_result", res, ref_div(a, d, c));
            check("rand_latency", lat, ref_lat(a, d, c));
            finish_op();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
